// File: rtl/reg_file_mux.sv
// reg_file_mux: multi-port register file with byte-enabled writes and
// registered (1-cycle) reads. Register 0 is hard-wired to zero.
// Optional feature macro: REG_FILE_MUX_BYPASS_EN. When defined, a write and a
// read of the same nonzero address at the same edge forward the written bytes
// to the read result. When undefined, the read returns the pre-write contents.
module reg_file_mux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       WrEn,
    input  logic [ADDR_W-1:0]          WrAddr,
    input  logic [DATA_W-1:0]          WrData,
    input  logic [DATA_W/8-1:0]        WrBe,
    input  logic [NUM_RD-1:0]          RdEn,
    input  logic [NUM_RD*ADDR_W-1:0]   RdAddr,
    output logic [NUM_RD*DATA_W-1:0]   RdData,
    output logic [NUM_RD-1:0]          RdValid
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    // Register 0 is not stored at all; it reads as zero by construction.
    logic [DATA_W-1:0] mem_q [1:DEPTH-1];

    logic [ADDR_W-1:0]        rd_idx  [NUM_RD];
    logic [DATA_W-1:0]        rd_word [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_data_q;
    logic [NUM_RD-1:0]        rd_valid_q;

    // Storage: async clear, byte-enabled write to any nonzero address.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (WrEn && (WrAddr != '0)) begin
            for (int b = 0; b < NB; b++) begin
                if (WrBe[b]) begin
                    mem_q[WrAddr][b*8 +: 8] <= WrData[b*8 +: 8];
                end
            end
        end
    end

    // Per-port read select: full AND-OR decode, then optional per-byte forwarding.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_idx[p]  = RdAddr[p*ADDR_W +: ADDR_W];
            rd_word[p] = '0;
            for (int a = 1; a < DEPTH; a++) begin
                if (rd_idx[p] == ADDR_W'(a)) begin
                    rd_word[p] = rd_word[p] | mem_q[a];
                end
            end
`ifdef REG_FILE_MUX_BYPASS_EN
            // Address 0 is excluded so the zero register is never overridden.
            if (WrEn && (WrAddr == rd_idx[p]) && (WrAddr != '0)) begin
                for (int b = 0; b < NB; b++) begin
                    if (WrBe[b]) begin
                        rd_word[p][b*8 +: 8] = WrData[b*8 +: 8];
                    end
                end
            end
`endif
        end
    end

    // Read pipeline register: capture on RdEn, otherwise hold data and drop valid.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_valid_q[p] <= RdEn[p];
                if (RdEn[p]) begin
                    rd_data_q[p*DATA_W +: DATA_W] <= rd_word[p];
                end
            end
        end
    end

    assign RdData  = rd_data_q;
    assign RdValid = rd_valid_q;

endmodule

// File: tb/tb_reg_file_mux.sv
// Self-checking bench for reg_file_mux: a default 32x32/2-port instance and a
// 16-bit/8-entry/4-port instance. Expected read results are queued when the
// read is issued and compared one cycle later.
module tb_reg_file_mux;

`ifdef REG_FILE_MUX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    // Default-parameter instance signals
    logic        a_wr_en;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [3:0]  a_wr_be;
    logic [1:0]  a_rd_en;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_valid;

    // Small instance signals
    logic        b_wr_en;
    logic [2:0]  b_wr_addr;
    logic [15:0] b_wr_data;
    logic [1:0]  b_wr_be;
    logic [3:0]  b_rd_en;
    logic [11:0] b_rd_addr;
    logic [63:0] b_rd_data;
    logic [3:0]  b_rd_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        sel;
        logic [63:0] data;
        logic [3:0]  valid;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    reg_file_mux dut_a (
        .Clk     (clk),
        .Rst_n   (rst_n),
        .WrEn    (a_wr_en),
        .WrAddr  (a_wr_addr),
        .WrData  (a_wr_data),
        .WrBe    (a_wr_be),
        .RdEn    (a_rd_en),
        .RdAddr  (a_rd_addr),
        .RdData  (a_rd_data),
        .RdValid (a_rd_valid)
    );

    reg_file_mux #(
        .DATA_W (16),
        .ADDR_W (3),
        .NUM_RD (4)
    ) dut_b (
        .Clk     (clk),
        .Rst_n   (rst_n),
        .WrEn    (b_wr_en),
        .WrAddr  (b_wr_addr),
        .WrData  (b_wr_data),
        .WrBe    (b_wr_be),
        .RdEn    (b_rd_en),
        .RdAddr  (b_rd_addr),
        .RdData  (b_rd_data),
        .RdValid (b_rd_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_front(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        if (!e.sel) begin
            check({tag, "_d0"}, {32'h0, a_rd_data[31:0]},  {32'h0, e.data[31:0]});
            check({tag, "_d1"}, {32'h0, a_rd_data[63:32]}, {32'h0, e.data[63:32]});
            check({tag, "_v"},  {62'h0, a_rd_valid},       {62'h0, e.valid[1:0]});
        end else begin
            check({tag, "_d"}, b_rd_data,          e.data);
            check({tag, "_v"}, {60'h0, b_rd_valid}, {60'h0, e.valid});
        end
    endtask

    // One cycle on the default instance; optionally queue and check read results.
    task automatic cyc_a(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic [1:0] re,
                         input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic chk, input logic [31:0] e0, input logic [31:0] e1,
                         input string tag);
        @(negedge clk);
        a_wr_en   = we;
        a_wr_addr = wa;
        a_wr_data = wd;
        a_wr_be   = be;
        a_rd_en   = re;
        a_rd_addr = {ra1, ra0};
        if (chk) sb.push_back('{sel: 1'b0, data: {e1, e0}, valid: {2'b00, re}});
        @(posedge clk);
        #1;
        if (chk) compare_front(tag);
    endtask

    task automatic cyc_b(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [3:0] re, input logic [11:0] ra,
                         input logic chk, input logic [63:0] e, input string tag);
        @(negedge clk);
        b_wr_en   = we;
        b_wr_addr = wa;
        b_wr_data = wd;
        b_wr_be   = 2'b11;
        b_rd_en   = re;
        b_rd_addr = ra;
        if (chk) sb.push_back('{sel: 1'b1, data: e, valid: re});
        @(posedge clk);
        #1;
        if (chk) compare_front(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_wr_be = '0;
        a_rd_en = '0;   a_rd_addr = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_be = '0;
        b_rd_en = '0;   b_rd_addr = '0;

        #1;
        check("rst_a_data",  a_rd_data, 64'h0);
        check("rst_a_valid", {62'h0, a_rd_valid}, 64'h0);
        check("rst_b_valid", {60'h0, b_rd_valid}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then dual-port read
        cyc_a(1, 5'd5, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 1, 32'h0, 32'h0, "wr_r5");
        cyc_a(0, 0, 0, 0, 2'b11, 5'd5, 5'd5, 1, 32'hDEADBEEF, 32'hDEADBEEF, "rd_r5");

        // Byte enables
        cyc_a(1, 5'd7, 32'h11223344, 4'hF, 2'b00, 0, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, "wr_r7");
        cyc_a(1, 5'd7, 32'hAABBCCDD, 4'b0101, 2'b00, 0, 0, 0, 0, 0, "");
        cyc_a(0, 0, 0, 0, 2'b11, 5'd7, 5'd7, 1, 32'h11BB33DD, 32'h11BB33DD, "rd_r7_be");

        // Zero register ignores writes
        cyc_a(1, 5'd0, 32'hFFFFFFFF, 4'hF, 2'b00, 0, 0, 0, 0, 0, "");
        cyc_a(0, 0, 0, 0, 2'b11, 5'd0, 5'd0, 1, 32'h0, 32'h0, "rd_r0");

        // All-zero byte enables leave storage unchanged
        cyc_a(1, 5'd5, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, "");
        cyc_a(0, 0, 0, 0, 2'b11, 5'd5, 5'd7, 1, 32'hDEADBEEF, 32'h11BB33DD, "rd_be0");

        // Port 1 disabled: valid drops, data holds
        cyc_a(0, 0, 0, 0, 2'b01, 5'd9, 5'd5, 1, 32'h0, 32'h11BB33DD, "hold_p1");

        // Same-address collision
        cyc_a(1, 5'd9, 32'h1, 4'hF, 2'b00, 0, 0, 0, 0, 0, "");
        cyc_a(1, 5'd9, 32'h2, 4'hF, 2'b11, 5'd9, 5'd9, 1,
              BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, "coll_r9");
        cyc_a(0, 0, 0, 0, 2'b11, 5'd9, 5'd9, 1, 32'h2, 32'h2, "after_coll_r9");

        // Per-byte collision on r7, with an independent read of r5
        cyc_a(1, 5'd7, 32'h0000EE00, 4'b0010, 2'b11, 5'd7, 5'd5, 1,
              BYP ? 32'h11BBEEDD : 32'h11BB33DD, 32'hDEADBEEF, "coll_byte_r7");
        cyc_a(0, 0, 0, 0, 2'b01, 5'd7, 5'd0, 1, 32'h11BBEEDD, 32'hDEADBEEF, "after_coll_r7");

        // Address 0 never forwarded
        cyc_a(1, 5'd0, 32'hFFFFFFFF, 4'hF, 2'b11, 5'd0, 5'd0, 1, 32'h0, 32'h0, "coll_r0");

        // Read r5 to make outputs nonzero, then reset mid-write without a clock edge
        cyc_a(0, 0, 0, 0, 2'b11, 5'd5, 5'd7, 1, 32'hDEADBEEF, 32'h11BBEEDD, "pre_rst");
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'h12345678; a_wr_be = 4'hF;
        a_rd_en = 2'b11; a_rd_addr = {5'd7, 5'd5};
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_data",  a_rd_data, 64'h0);
        check("async_rst_valid", {62'h0, a_rd_valid}, 64'h0);
        @(posedge clk);
        #1;
        check("rst_hold_valid", {62'h0, a_rd_valid}, 64'h0);
        check("rst_hold_data",  a_rd_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a_wr_en = 1'b0;

        // Every address reads zero after reset
        for (int i = 0; i < 32; i++) begin
            cyc_a(0, 0, 0, 0, 2'b11, 5'(i), 5'(31 - i), 1, 32'h0, 32'h0, "post_rst_rd");
        end

        // Small-parameter instance: fill r1..r7, read all four ports together
        for (int i = 1; i < 8; i++) begin
            cyc_b(1, 3'(i), 16'(i * 16'h1111), 4'b0000, 12'h0, 0, 64'h0, "");
        end
        cyc_b(0, 0, 0, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 1,
              64'h4444_3333_2222_1111, "b_rd_1234");
        cyc_b(0, 0, 0, 4'b1111, {3'd0, 3'd7, 3'd6, 3'd5}, 1,
              64'h0000_7777_6666_5555, "b_rd_5670");
        cyc_b(0, 0, 0, 4'b1111, {3'd3, 3'd3, 3'd3, 3'd3}, 1,
              64'h3333_3333_3333_3333, "b_rd_same");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
